// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and auto-repeat a bank of pushbuttons
module button_conditioner #(
    parameter int CHANNELS        = 5,
    parameter int CNT_W           = 26,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 16_777_216
) (
    input  logic                i_clk_sys,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_button_in,
    input  logic [CHANNELS-1:0] i_repeat_en,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_key_strobe
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] r_rpt_cnt;
        logic [1:0]       r_state;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             r_strobe;

        logic             w_differ;
        logic             w_accept;
        logic             w_rise;
        logic             w_fall;
        logic [1:0]       w_state_next;
        logic [CNT_W-1:0] w_rpt_next;
        logic             w_rpt_pulse;

        assign w_differ = (r_sync2 != r_level);
        assign w_accept = w_differ && (r_db_cnt == DB_LAST);
        assign w_rise   = w_accept && r_sync2;
        assign w_fall   = w_accept && !r_sync2;

        // A release or a dropped enable on the deadline cycle suppresses the repeat.
        always_comb begin
            w_state_next = r_state;
            w_rpt_next   = r_rpt_cnt;
            w_rpt_pulse  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_DELAY;
                        w_rpt_next   = '0;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (w_fall || !i_repeat_en[g]) begin
                        w_state_next = ST_IDLE;
                        w_rpt_next   = '0;
                    end else if (r_rpt_cnt == ((r_state == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        w_state_next = ST_REPEAT;
                        w_rpt_next   = '0;
                        w_rpt_pulse  = 1'b1;
                    end else begin
                        w_rpt_next   = r_rpt_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_rpt_next   = '0;
                end
            endcase
        end

        always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_db_cnt  <= '0;
                r_rpt_cnt <= '0;
                r_state   <= ST_IDLE;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_strobe  <= 1'b0;
            end else begin
                r_sync1 <= i_button_in[g];
                r_sync2 <= r_sync1;
                if (!w_differ || w_accept) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_ONE;
                end
                if (w_accept) begin
                    r_level <= r_sync2;
                end
                r_press   <= w_rise;
                r_release <= w_fall;
                r_strobe  <= w_rise | w_rpt_pulse;
                r_state   <= w_state_next;
                r_rpt_cnt <= w_rpt_next;
            end
        end

        assign o_level[g]      = r_level;
        assign o_press[g]      = r_press;
        assign o_release[g]    = r_release;
        assign o_key_strobe[g] = r_strobe;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn   = 2'b00;
    logic [1:0] ren   = 2'b11;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] ks;
    logic [7:0] got;
    logic [7:0] exp;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS(2),
        .CNT_W(8),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .i_clk_sys(clk),
        .i_rst_n(rst_n),
        .i_button_in(btn),
        .i_repeat_en(ren),
        .o_level(level),
        .o_press(press),
        .o_release(rel),
        .o_key_strobe(ks)
    );

    assign got = {level, press, rel, ks};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        btn   = 2'b00;
        ren   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = 2'b11;
        repeat (2) tick();
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got=%h exp=00", got);
        end
        repeat (6) tick();
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=00", got);
        end
        apply_reset();
    endtask

    task automatic test_press_repeat;
        apply_reset();
        for (int e = 0; e <= 24; e++) begin
            btn = 2'b01;
            tick();
            exp = {1'b0, (e >= 5), 1'b0, (e == 5), 2'b00,
                   1'b0, (e == 5 || (e >= 15 && (e - 15) % 3 == 0))};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL press_repeat e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_bounce;
        apply_reset();
        for (int e = 0; e <= 20; e++) begin
            btn = {1'b0, (e == 2 || e == 4 || e >= 10)};
            tick();
            exp = {1'b0, (e >= 15), 1'b0, (e == 15), 2'b00, 1'b0, (e == 15)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bounce e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_repeat_disable;
        apply_reset();
        for (int e = 0; e <= 66; e++) begin
            btn = {1'b0, (e <= 40 || e >= 50)};
            ren = {1'b1, (e != 26)};
            tick();
            exp = {1'b0, ((e >= 5 && e < 46) || e >= 55),
                   1'b0, (e == 5 || e == 55),
                   1'b0, (e == 46),
                   1'b0, (e == 5 || e == 15 || e == 18 || e == 21 || e == 24 || e == 55 || e == 65)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL repeat_disable e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_release_on_deadline;
        apply_reset();
        for (int e = 0; e <= 30; e++) begin
            btn = {1'b0, (e < 16)};
            tick();
            exp = {1'b0, (e >= 5 && e < 21), 1'b0, (e == 5), 1'b0, (e == 21),
                   1'b0, (e == 5 || e == 15 || e == 18)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL release_deadline e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_two_channels;
        apply_reset();
        for (int e = 0; e <= 23; e++) begin
            btn = {(e >= 2), 1'b1};
            tick();
            exp = {(e >= 7), (e >= 5), (e == 7), (e == 5), 2'b00,
                   (e == 7 || (e >= 17 && (e - 17) % 3 == 0)),
                   (e == 5 || (e >= 15 && (e - 15) % 3 == 0))};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL two_channels e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        apply_reset();
        for (int e = 0; e <= 18; e++) begin
            btn = 2'b01;
            tick();
        end
        checks++;
        if (got !== 8'h41) begin
            failures++;
            $display("FAIL pre_reset_strobe got=%h exp=41", got);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got=%h exp=00", got);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = {1'b0, (e >= 5), 1'b0, (e == 5), 2'b00, 1'b0, (e == 5)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset_press e=%0d got=%h exp=%h", e, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_bounce();
        test_repeat_disable();
        test_release_on_deadline();
        test_two_channels();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
